pipe_reg_chain: RTL
===================

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter: WIDTH, default 10, payload bits per entry (legal 1..256).
REQ-002 Parameter: DEPTH, default 2, number of register stages (legal 1..16).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: flush  input  1  squash every held entry; sampled on clk.
REQ-006 Port: in_valid  input  1  upstream presents in_data.
REQ-007 Port: in_ready  output  1  chain accepts in_data this cycle.
REQ-008 Port: in_data  input  WIDTH  upstream payload.
REQ-009 Port: out_valid  output  1  out_data holds a live entry.
REQ-010 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 Port: out_data  output  WIDTH  payload of the output-side stage.
REQ-012 Port: occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-013 Stages are numbered 0 (input side) to DEPTH-1 (output side); each holds one valid bit and one WIDTH-bit data register.
REQ-014 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-015 Stage DEPTH-1 advances when valid and out_ready; stage i<DEPTH-1 advances when valid and (stage i+1 empty or stage i+1 advances).
REQ-016 Stage i captures when empty or advancing; source is in_data for stage 0, stage i-1 data otherwise; the captured valid equals the source valid (bubbles propagate and collapse).
REQ-017 A data register loads only on a capture with a valid source; otherwise it holds (no toggling on stall or on a bubble).
REQ-018 in_ready = (stage 0 empty or stage 0 advances) & ~flush; combinational from out_ready through the ready chain.
REQ-019 out_valid = valid[DEPTH-1] & ~flush; out_data = data[DEPTH-1] at all times.
REQ-020 Latency: an entry accepted at edge t into an empty chain with out_ready=1 shows out_valid=1 in the cycle after edge t+DEPTH-1 (DEPTH cycles after the in-transfer cycle).
REQ-021 Throughput: one entry per cycle sustained when out_ready=1; no bubble is inserted by the chain.
REQ-022 Full (all DEPTH valid) with out_ready=0: in_ready=0, all state holds.
REQ-023 Full with out_ready=1: in_ready=1; simultaneous in and out transfer; occupancy unchanged.
REQ-024 Empty: out_valid=0; occupancy=0; in_ready=1 unless flush.
REQ-025 Flush: at the next edge all valid bits clear; in_ready=0 and out_valid=0 during the flush cycle; no in or out transfer occurs in that cycle; data registers hold.
REQ-026 Order is preserved: entries leave in acceptance order, no duplication, no loss except by flush or reset.
REQ-027 occupancy = population count of valid bits, registered-state based (not including the same-cycle transfer).

Reset
REQ-028 reset asserted: all valid bits 0, all data registers 0, asynchronously, without waiting for clk.
REQ-029 Outputs under reset: in_ready=0, out_valid=0, out_data=0, occupancy=0.
REQ-030 Reset asserted mid-operation discards all entries; after deassertion the chain behaves as empty from the next edge.

Structure
REQ-031 Package pipe_reg_pkg holds DEFAULT_WIDTH=10, DEFAULT_DEPTH=2 and the occupancy-width helper function.
REQ-032 One sub-module pipe_reg_stage (valid bit plus WIDTH-bit enable register, async reset) instantiated DEPTH times in a generate loop.
REQ-033 Top level holds only the advance/ready chain, flush masking and occupancy count.

Verification (WIDTH=10, DEPTH=3)
REQ-034 Reset, then push 0x155 with out_ready=1 -> out_valid=1, out_data=0x155 exactly 3 cycles after the in-transfer cycle; occupancy 1,1,1 then 0.
REQ-035 Stream 0x001..0x008 back-to-back, out_ready=1 -> in_ready stays 1; outputs 0x001..0x008 on consecutive cycles in order.
REQ-036 out_ready=0, push 0x0A0,0x0A1,0x0A2,0x0A3 -> first three accepted, in_ready=0 on fourth, occupancy=3; raise out_ready -> 0x0A3 accepted same cycle as 0x0A0 leaves.
REQ-037 Push 0x011, idle one cycle, push 0x022, out_ready=0 -> bubble collapses: occupancy=2 with stages 2,1 valid; drain yields 0x011 then 0x022.
REQ-038 Full chain, assert flush with in_valid=1, in_data=0x3FF -> in_ready=0, out_valid=0 that cycle; next cycle occupancy=0; 0x3FF never appears.
REQ-039 Assert reset asynchronously between edges with occupancy=2 -> out_valid, occupancy, out_data drop to 0 before the next edge; following push 0x123 emerges alone.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// pipe_reg_pkg : shared defaults and occupancy-width helper for pipe_reg_chain
// Rev 1.0
// ============================================================================
package pipe_reg_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_DEPTH = 2;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_stage.sv
`default_nettype none
// ============================================================================
// pipe_reg_stage : one valid bit plus an enable-loaded payload register
// Rev 1.0
// ============================================================================
module pipe_reg_stage #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_cap,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Payload only loads with a live source, so bubbles and stalls never toggle it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_cap) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// pipe_reg_chain : DEPTH-stage valid/ready register chain with bubble collapse
// Rev 1.0
// ============================================================================
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(DEPTH)-1:0]    occupancy
);

    localparam int OW = occ_width(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_cap;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_out_go;
    logic             w_in_go;
    logic [OW-1:0]    w_occ;

    assign w_out_go = out_ready & ~flush;

    // A stage advances when it is valid and either some stage downstream of it
    // is empty (the chain can shuffle forward) or the whole tail is full and
    // the output side is draining.
    always_comb begin
        w_adv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic w_tail_full;
            w_tail_full = 1'b1;
            for (int j = i + 1; j < DEPTH; j++) begin
                w_tail_full = w_tail_full & w_valid[j];
            end
            w_adv[i] = w_valid[i] & (~w_tail_full | w_out_go);
        end
    end

    assign w_cap    = ~w_valid | w_adv;
    assign in_ready = w_cap[0] & ~flush & ~reset;
    assign w_in_go  = in_valid & in_ready;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            logic             w_src_valid;
            logic [WIDTH-1:0] w_src_data;

            if (g == 0) begin : g_first
                assign w_src_valid = w_in_go;
                assign w_src_data  = in_data;
            end else begin : g_rest
                assign w_src_valid = w_valid[g-1];
                assign w_src_data  = w_data[g-1];
            end

            pipe_reg_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst     (reset),
                .i_flush (flush),
                .i_cap   (w_cap[g]),
                .i_valid (w_src_valid),
                .i_data  (w_src_data),
                .o_valid (w_valid[g]),
                .o_data  (w_data[g])
            );
        end
    endgenerate

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OW'(w_valid[i]);
        end
    end

    assign occupancy = w_occ;
    assign out_valid = w_valid[DEPTH-1] & ~flush;
    assign out_data  = w_data[DEPTH-1];

endmodule
`default_nettype wire
